// File: rtl/mdc_reorder_out_if.sv
// AXI4-Stream bus carrying natural-order FFT bins out of mdc_reorder_out.
// tdata = {real, imag}; a beat transfers on any rising edge where tvalid && tready.
interface mdc_reorder_out_if #(
  parameter int NB = 12
);
  logic            tvalid;
  logic [2*NB-1:0] tdata;
  logic            tlast;
  logic            tready;

  // valid/ready: once tvalid is high, tdata/tlast stay stable and tvalid stays high until tready is seen.
  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/mdc_reorder_out.sv
// Bit-reversed two-lane MDC output reordered through a ping-pong buffer into a serial AXIS stream.
// Optional macro MDC_REORDER_SCALE_EN: divide each output component by N_POINTS (round half up, saturate).
module mdc_reorder_out #(
  parameter int NB       = 12,
  parameter int N_POINTS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic signed [NB-1:0] i_data0_r,
  input  logic signed [NB-1:0] i_data0_i,
  input  logic signed [NB-1:0] i_data1_r,
  input  logic signed [NB-1:0] i_data1_i,
  output logic                 o_in_ready,
  output logic                 o_overflow,
  output logic [1:0]           o_rd_state,
  mdc_reorder_out_if.master    m_axis_data
);

  localparam int LOG2N = $clog2(N_POINTS);
  localparam logic [LOG2N-2:0] WCNT_LAST = (LOG2N-1)'(N_POINTS/2 - 1);
  localparam logic [LOG2N-1:0] RCNT_LAST = LOG2N'(N_POINTS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STREAM = 2'd2} rd_state_t;

  rd_state_t       state, state_nxt;
  logic [2*NB-1:0] mem [2][N_POINTS];
  logic [LOG2N-2:0] wcnt;
  logic [LOG2N-1:0] rcnt, rcnt_inc;
  logic            wbank, rbank;
  logic [1:0]      full;
  logic            frame_ok;
  logic            tvalid_q, tlast_q;
  logic [2*NB-1:0] tdata_q;
  logic            frame_start, pair_last, wr_en, in_ready;
  logic            rd_fire, frame_done, freeing;
  logic [LOG2N-1:0] addr0, addr1;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  function automatic logic [NB-1:0] scale(input logic [NB-1:0] x);
`ifdef MDC_REORDER_SCALE_EN
    logic signed [NB:0] sum, shr;
    sum = $signed({x[NB-1], x}) + $signed((NB+1)'(N_POINTS/2));
    shr = sum >>> LOG2N;
    if (shr > $signed((NB+1)'(2**(NB-1) - 1))) return NB'(2**(NB-1) - 1);
    return shr[NB-1:0];
`else
    return x;
`endif
  endfunction

  function automatic logic [2*NB-1:0] out_word(input logic [2*NB-1:0] w);
    return {scale(w[2*NB-1:NB]), scale(w[NB-1:0])};
  endfunction

  // Write side: frame acceptance is decided once, on pair 0, and held for the rest of the frame.
  assign frame_start = i_valid && (wcnt == '0);
  assign pair_last   = (wcnt == WCNT_LAST);
  assign rd_fire     = (state == STREAM) && tvalid_q && m_axis_data.tready;
  assign frame_done  = rd_fire && (rcnt == RCNT_LAST);
  assign freeing     = frame_done && (rbank == wbank);
  assign in_ready    = !full[wbank] || freeing;
  assign wr_en       = i_valid && (frame_start ? in_ready : frame_ok);
  assign addr0       = bitrev({wcnt, 1'b0});
  assign addr1       = bitrev({wcnt, 1'b1});
  assign rcnt_inc    = rcnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wbank][addr0] <= {i_data0_r, i_data0_i};
      mem[wbank][addr1] <= {i_data1_r, i_data1_i};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wcnt       <= '0;
      wbank      <= 1'b0;
      frame_ok   <= 1'b0;
      o_overflow <= 1'b0;
      full       <= 2'b00;
    end else begin
      if (i_valid) begin
        wcnt <= pair_last ? '0 : wcnt + 1'b1;
        if (frame_start) begin
          frame_ok <= in_ready;
          if (!in_ready) o_overflow <= 1'b1;
        end
        if (wr_en && pair_last) wbank <= ~wbank;
      end
      for (int b = 0; b < 2; b++) begin
        if (wr_en && pair_last && (wbank == 1'(b)))
          full[b] <= 1'b1;
        else if (frame_done && (rbank == 1'(b)))
          full[b] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full[rbank]) state_nxt = LOAD;
      LOAD:    state_nxt = STREAM;
      STREAM:  if (frame_done) state_nxt = full[~rbank] ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output register: bin 0 loads in LOAD, each handshake loads the next bin so there are no bubbles.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      rcnt     <= '0;
      rbank    <= 1'b0;
    end else if (state == LOAD) begin
      tvalid_q <= 1'b1;
      tlast_q  <= 1'b0;
      tdata_q  <= out_word(mem[rbank][0]);
      rcnt     <= '0;
    end else if (frame_done) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      rcnt     <= '0;
      rbank    <= ~rbank;
    end else if (rd_fire) begin
      tdata_q  <= out_word(mem[rbank][rcnt_inc]);
      tlast_q  <= (rcnt_inc == RCNT_LAST);
      rcnt     <= rcnt_inc;
    end
  end

  assign m_axis_data.tvalid = tvalid_q;
  assign m_axis_data.tdata  = tdata_q;
  assign m_axis_data.tlast  = tlast_q;
  assign o_in_ready         = in_ready;
  assign o_rd_state         = state;

endmodule
